// File: rtl/synth_pkg.sv
// Shared synth definitions: envelope state encoding and amplitude constants.
// Used by adsr_env now and by the LFO and sequencer later.
package synth_pkg;

   localparam int              AMP_W   = 16;
   localparam logic [AMP_W-1:0] AMP_MAX = 16'h7fff;

   typedef enum logic [2:0] {
      IDLE,
      ATTACK,
      DECAY,
      SUSTAIN,
      RELEASE
   } env_state_t;

endpackage

// File: rtl/tick_gen.sv
// Clock-enable divider: strobes o_tick for one cycle every CLK_DIV cycles.
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   o_tick   combinational decode of the counter terminal value (count == CLK_DIV-1)
// CLK_DIV legal range 1..65535; CLK_DIV=1 holds o_tick high every cycle.
module tick_gen #(
   parameter int CLK_DIV = 1000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_tick
);

   localparam int            CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count <= '0;
      end else if (count == TC) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign o_tick = (count == TC);

endmodule

// File: rtl/adsr_env.sv
// ADSR envelope generator driving the amplitude input of the amp block.
// Linear attack/decay/release steps applied once per envelope tick.
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_gate     note gate; rising edge triggers, low releases
//   i_attack   attack step per tick (0 = instant)
//   i_decay    decay step per tick (0 = instant)
//   i_sustain  sustain level, clamped to AMP_MAX
//   i_release  release step per tick (0 = instant)
//   o_amp      envelope level, registered, 0..AMP_MAX
//   o_active   registered copy of (state != IDLE)
//   o_tick     registered envelope tick strobe
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | level held at 0, waiting for a gate rising edge
// ATTACK  | level rises by i_attack per tick up to AMP_MAX
// DECAY   | level falls by i_decay per tick down to sustain
// SUSTAIN | level tracks min(i_sustain, AMP_MAX)
// RELEASE | level falls by i_release per tick down to 0
module adsr_env
   import synth_pkg::*;
#(
   parameter int         CLK_DIV = 1000,
   parameter logic [15:0] AMP_MAX = synth_pkg::AMP_MAX
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_gate,
   input  logic [15:0] i_attack,
   input  logic [15:0] i_decay,
   input  logic [15:0] i_sustain,
   input  logic [15:0] i_release,
   output logic [15:0] o_amp,
   output logic        o_active,
   output logic        o_tick
);

   logic       tick;
   logic       gate_q;
   logic       rise_pend;
   logic       rise;
   logic       trig;
   env_state_t state;
   logic [15:0] level;

   logic [15:0]        sus_lvl;
   logic [16:0]        atk_sum;
   logic               atk_sat;
   logic signed [16:0] dec_diff;
   logic signed [16:0] rel_diff;

   tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .o_tick  (tick)
   );

   // A gate pulse shorter than a tick period is latched until the next tick.
   assign rise = i_gate & ~gate_q;
   assign trig = rise | rise_pend;

   // 17-bit arithmetic so neither overflow nor underflow can wrap the level.
   assign sus_lvl  = (i_sustain > AMP_MAX) ? AMP_MAX : i_sustain;
   assign atk_sum  = {1'b0, level} + {1'b0, i_attack};
   assign atk_sat  = (i_attack == 16'd0) || (atk_sum >= {1'b0, AMP_MAX});
   assign dec_diff = $signed({1'b0, level}) - $signed({1'b0, i_decay});
   assign rel_diff = $signed({1'b0, level}) - $signed({1'b0, i_release});

   assign o_amp = level;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         level     <= '0;
         gate_q    <= 1'b0;
         rise_pend <= 1'b0;
         o_tick    <= 1'b0;
         o_active  <= 1'b0;
      end else begin
         gate_q   <= i_gate;
         o_tick   <= tick;
         o_active <= (state != IDLE);

         if (tick) begin
            rise_pend <= 1'b0;
         end else if (rise) begin
            rise_pend <= 1'b1;
         end

         if (tick) begin
            // A trigger performs a full attack step from the current level
            // (legato), including the hand-off to DECAY when it saturates.
            if (trig) begin
               if (atk_sat) begin
                  level <= AMP_MAX;
                  state <= DECAY;
               end else begin
                  level <= atk_sum[15:0];
                  state <= ATTACK;
               end
            end else if (!i_gate && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
               state <= RELEASE;
            end else begin
               case (state)
                  IDLE: begin
                     level <= '0;
                  end
                  ATTACK: begin
                     if (atk_sat) begin
                        level <= AMP_MAX;
                        state <= DECAY;
                     end else begin
                        level <= atk_sum[15:0];
                     end
                  end
                  DECAY: begin
                     if (i_decay == 16'd0 || dec_diff <= $signed({1'b0, sus_lvl})) begin
                        level <= sus_lvl;
                        state <= SUSTAIN;
                     end else begin
                        level <= dec_diff[15:0];
                     end
                  end
                  SUSTAIN: begin
                     level <= sus_lvl;
                  end
                  RELEASE: begin
                     if (i_release == 16'd0 || rel_diff <= 17'sd0) begin
                        level <= '0;
                        state <= IDLE;
                     end else begin
                        level <= rel_diff[15:0];
                     end
                  end
                  default: begin
                     level <= '0;
                     state <= IDLE;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_adsr_env.sv
// Directed bench for adsr_env: one instance with a tick every cycle, one with
// a tick every 4th cycle. Expected values are hand-computed constants.
module tb_adsr_env;

   logic        clk;
   logic        rst_n;
   logic        gate1;
   logic        gate4;
   logic [15:0] attack;
   logic [15:0] decay;
   logic [15:0] sustain;
   logic [15:0] release_step;
   logic [15:0] amp1;
   logic [15:0] amp4;
   logic        active1;
   logic        active4;
   logic        tick1;
   logic        tick4;

   int total  = 0;
   int passed = 0;

   adsr_env #(.CLK_DIV(1)) dut1 (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_gate    (gate1),
      .i_attack  (attack),
      .i_decay   (decay),
      .i_sustain (sustain),
      .i_release (release_step),
      .o_amp     (amp1),
      .o_active  (active1),
      .o_tick    (tick1)
   );

   adsr_env #(.CLK_DIV(4)) dut4 (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_gate    (gate4),
      .i_attack  (attack),
      .i_decay   (decay),
      .i_sustain (sustain),
      .i_release (release_step),
      .o_amp     (amp4),
      .o_active  (active4),
      .o_tick    (tick4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int n;
      rst_n        = 1'b1;
      gate1        = 1'b0;
      gate4        = 1'b0;
      attack       = 16'h1000;
      decay        = 16'h0800;
      sustain      = 16'h4000;
      release_step = 16'h0400;

      // Reset asserted mid-clock, outputs clear immediately.
      #2 rst_n = 1'b0;
      #1;
      check("rst_amp1", amp1, 16'h0000);
      check("rst_active1", active1, 1'b0);
      check("rst_tick1", tick1, 1'b0);
      check("rst_amp4", amp4, 16'h0000);
      step(2);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(1);
         check("idle_amp", amp1, 16'h0000);
         check("idle_active", active1, 1'b0);
      end

      // Attack then decay into sustain.
      gate1 = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step(1);
         check("attack", amp1, 16'h1000 * k);
      end
      step(1);
      check("attack_top", amp1, 16'h7fff);
      for (int k = 0; k < 7; k++) begin
         step(1);
         check("decay", amp1, 16'h77ff - 16'h0800 * k);
      end
      step(1);
      check("decay_clamp", amp1, 16'h4000);
      step(2);
      check("sustain", amp1, 16'h4000);
      check("sustain_active", active1, 1'b1);

      // Release.
      gate1 = 1'b0;
      step(1);
      check("rel_hold", amp1, 16'h4000);
      for (int k = 1; k <= 15; k++) begin
         step(1);
         check("release", amp1, 16'h4000 - 16'h0400 * k);
      end
      step(1);
      check("rel_zero", amp1, 16'h0000);
      check("rel_active_lag", active1, 1'b1);
      step(1);
      check("rel_inactive", active1, 1'b0);

      // Retrigger during release.
      gate1 = 1'b1;
      step(18);
      check("sustain2", amp1, 16'h4000);
      gate1 = 1'b0;
      step(1);
      check("rel2_hold", amp1, 16'h4000);
      step(8);
      check("rel2_at_2000", amp1, 16'h2000);
      gate1 = 1'b1;
      step(1);
      check("retrig_amp", amp1, 16'h3000);
      check("retrig_active", active1, 1'b1);
      step(1);
      check("retrig_attack", amp1, 16'h4000);

      // Instant steps and sustain clamp.
      attack       = 16'h0000;
      decay        = 16'h0000;
      sustain      = 16'h9000;
      release_step = 16'h0000;
      gate1        = 1'b0;
      step(1);
      check("inst_rel_hold", amp1, 16'h4000);
      step(1);
      check("inst_rel_zero", amp1, 16'h0000);
      gate1 = 1'b1;
      step(1);
      check("inst_attack", amp1, 16'h7fff);
      step(1);
      check("inst_decay", amp1, 16'h7fff);
      step(1);
      check("inst_sustain", amp1, 16'h7fff);
      gate1 = 1'b0;
      step(1);
      check("inst_rel_hold2", amp1, 16'h7fff);
      step(1);
      check("inst_rel_zero2", amp1, 16'h0000);
      step(1);
      check("inst_inactive", active1, 1'b0);

      // CLK_DIV=4: sync to a tick, then short gate pulse between ticks.
      attack       = 16'h1000;
      decay        = 16'h0800;
      sustain      = 16'h4000;
      release_step = 16'h0400;
      n = 0;
      step(1);
      while (!tick4 && n < 10) begin
         step(1);
         n++;
      end
      check("div4_sync", tick4, 1'b1);
      gate4 = 1'b1;
      step(1);
      gate4 = 1'b0;
      check("div4_t1", tick4, 1'b0);
      check("div4_amp1", amp4, 16'h0000);
      step(1);
      check("div4_t2", tick4, 1'b0);
      step(1);
      check("div4_t3", tick4, 1'b0);
      check("div4_amp3", amp4, 16'h0000);
      step(1);
      check("div4_t4", tick4, 1'b1);
      check("div4_pulse_attack", amp4, 16'h1000);
      step(1);
      check("div4_active", active4, 1'b1);
      step(2);
      check("div4_hold", amp4, 16'h1000);
      step(1);
      check("div4_release_hold", amp4, 16'h1000);
      step(4);
      check("div4_release_step", amp4, 16'h0c00);

      // Reset mid-operation discards a pending trigger.
      gate4 = 1'b1;
      step(1);
      gate4 = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_amp4", amp4, 16'h0000);
      check("midrst_active4", active4, 1'b0);
      check("midrst_tick4", tick4, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step(12);
      check("midrst_no_trig", amp4, 16'h0000);
      check("midrst_idle", active4, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
